// File: rtl/apb_arbiter.sv
// ============================================================================
// Module   : apb_arbiter
// Purpose  : Two-requester round-robin arbiter driving a single APB master
//            port (IDLE/SETUP/ACCESS, no wait states, registered outputs).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_grant;
  logic                w_complete;
  logic                w_elig0;
  logic                w_elig1;
  logic                w_any;
  logic                w_win;

  logic                r_last;
  logic                r_owner;
  logic                r_gnt0;
  logic                r_gnt1;
  logic                r_done0;
  logic                r_done1;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic [ADDR_W-1:0]   r_paddr;
  logic                r_pwrite;
  logic                r_psel;
  logic                r_penable;
  logic [DATA_W-1:0]   r_pwdata;

  // A requester still seeing its done pulse must not be re-granted this edge.
  assign w_elig0 = req0 & ~r_done0;
  assign w_elig1 = req1 & ~r_done1;
  assign w_any   = w_elig0 | w_elig1;
  assign w_win   = (w_elig0 & w_elig1) ? ~r_last : w_elig1;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_SETUP;
          w_grant     = 1'b1;
        end
      end
      S_SETUP: begin
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        w_state_nxt = S_IDLE;
        w_complete  = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last    <= 1'b1;
      r_owner   <= 1'b0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwdata  <= '0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      if (w_grant) begin
        r_owner   <= w_win;
        r_last    <= w_win;
        r_paddr   <= w_win ? addr1  : addr0;
        r_pwrite  <= w_win ? wr1    : wr0;
        r_pwdata  <= w_win ? wdata1 : wdata0;
        r_psel    <= 1'b1;
        r_penable <= 1'b0;
        r_gnt0    <= ~w_win;
        r_gnt1    <= w_win;
      end else if (r_state == S_SETUP) begin
        r_penable <= 1'b1;
      end else if (w_complete) begin
        r_psel    <= 1'b0;
        r_penable <= 1'b0;
        r_gnt0    <= 1'b0;
        r_gnt1    <= 1'b0;
        r_done0   <= ~r_owner;
        r_done1   <= r_owner;
        if (!r_pwrite) begin
          if (r_owner) begin
            r_rdata1 <= prdata;
          end else begin
            r_rdata0 <= prdata;
          end
        end
      end
    end
  end

  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign done0   = r_done0;
  assign done1   = r_done1;
  assign rdata0  = r_rdata0;
  assign rdata1  = r_rdata1;
  assign paddr   = r_paddr;
  assign pwrite  = r_pwrite;
  assign psel    = r_psel;
  assign penable = r_penable;
  assign pwdata  = r_pwdata;

endmodule

`default_nettype wire

// File: tb/tb_apb_arbiter.sv
// ============================================================================
// Module   : tb_apb_arbiter
// Purpose  : Directed self-checking bench for apb_arbiter with a small APB
//            slave memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, done0, done1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] paddr;
  logic          pwrite, psel, penable;
  logic [DW-1:0] pwdata, prdata;
  logic [DW-1:0] mem [0:15];

  int checks = 0;
  int errors = 0;

  apb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pwdata(pwdata), .prdata(prdata)
  );

  always #5 clk = ~clk;

  // Slave: writes land on the edge leaving ACCESS; reads are combinational.
  assign prdata = mem[paddr[3:0]];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE_0000 | i;
    forever begin
      @(posedge clk);
      if (psel && penable && pwrite) mem[paddr[3:0]] = pwdata;
    end
  end

  a_en_needs_sel: assert property (@(posedge clk) disable iff (!rst_n) !(penable && !psel))
    else $error("FAIL en_needs_sel: penable=1 while psel=0");

  task automatic tick();
    @(posedge clk);
    #1;
    checks++;
    if ((gnt0 && gnt1) || (done0 && done1)) begin
      errors++;
      $display("FAIL exclusive: gnt=%b%b done=%b%b, required never both high", gnt0, gnt1, done0, done1);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({psel, penable, pwrite, gnt0, gnt1, done0, done1} !== 7'b0 ||
        paddr !== '0 || pwdata !== '0 || rdata0 !== '0 || rdata1 !== '0) begin
      errors++;
      $display("FAIL reset_vals: ctl=%b paddr=%h pwdata=%h rdata0=%h rdata1=%h, required all 0",
               {psel, penable, pwrite, gnt0, gnt1, done0, done1}, paddr, pwdata, rdata0, rdata1);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic test_write();
    req0 = 1'b1; wr0 = 1'b1; addr0 = 8'h02; wdata0 = 32'h10;
    tick();
    checks++;
    if (paddr !== 8'h02 || pwrite !== 1'b1 || pwdata !== 32'h10 || psel !== 1'b1 ||
        penable !== 1'b0 || gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL wr_setup: paddr=%h pwrite=%b pwdata=%h psel=%b pen=%b gnt=%b%b, required 02 1 10 1 0 10",
               paddr, pwrite, pwdata, psel, penable, gnt0, gnt1);
    end
    req0 = 1'b0; addr0 = 8'hFF; wdata0 = 32'hDEAD;
    tick();
    checks++;
    if (psel !== 1'b1 || penable !== 1'b1 || paddr !== 8'h02 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL wr_access: psel=%b pen=%b paddr=%h done0=%b, required 1 1 02 0", psel, penable, paddr, done0);
    end
    tick();
    checks++;
    if (done0 !== 1'b1 || done1 !== 1'b0 || psel !== 1'b0 || penable !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL wr_done: done=%b%b psel=%b pen=%b gnt=%b%b, required done0 only", done0, done1, psel, penable, gnt0, gnt1);
    end
    tick();
    checks++;
    if (done0 !== 1'b0 || paddr !== 8'h02 || pwrite !== 1'b1 || pwdata !== 32'h10) begin
      errors++;
      $display("FAIL wr_idle_hold: done0=%b paddr=%h pwrite=%b pwdata=%h, required 0 02 1 10", done0, paddr, pwrite, pwdata);
    end
  endtask

  task automatic test_readback();
    req0 = 1'b1; wr0 = 1'b0; addr0 = 8'h02;
    tick();
    req0 = 1'b0;
    tick();
    tick();
    checks++;
    if (done0 !== 1'b1 || rdata0 !== 32'h10 || rdata1 !== '0) begin
      errors++;
      $display("FAIL rd_back: done0=%b rdata0=%h rdata1=%h, required 1 10 0", done0, rdata0, rdata1);
    end
    tick();
    req0 = 1'b1; wr0 = 1'b1; addr0 = 8'h04; wdata0 = 32'h20;
    tick();
    req0 = 1'b0;
    tick();
    tick();
    checks++;
    if (done0 !== 1'b1 || rdata0 !== 32'h10) begin
      errors++;
      $display("FAIL wr_keeps_rdata: done0=%b rdata0=%h, required 1 10", done0, rdata0);
    end
    tick();
  endtask

  task automatic test_tie();
    int g0, g1, d0, d1;
    g0 = -1; g1 = -1; d0 = -1; d1 = -1;
    do_reset();
    req0 = 1'b1; wr0 = 1'b1; addr0 = 8'h01; wdata0 = 32'h05;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 8'h08; wdata1 = 32'h10;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (gnt0 && g0 < 0) g0 = c;
      if (done0 && d0 < 0) d0 = c;
      if (done1 && d1 < 0) d1 = c;
      if (gnt1 && g1 < 0) begin
        g1 = c;
        checks++;
        if (paddr !== 8'h08 || pwrite !== 1'b1 || pwdata !== 32'h10) begin
          errors++;
          $display("FAIL tie_req1_setup: paddr=%h pwrite=%b pwdata=%h, required 08 1 10", paddr, pwrite, pwdata);
        end
      end
      if (gnt0) req0 = 1'b0;
      if (gnt1) req1 = 1'b0;
    end
    checks++;
    if (g0 != 1 || d0 != 3 || g1 != 4 || d1 != 6 || (d1 - d0) != 3) begin
      errors++;
      $display("FAIL tie_order: gnt0@%0d done0@%0d gnt1@%0d done1@%0d, required 1 3 4 6", g0, d0, g1, d1);
    end
  endtask

  task automatic test_fairness();
    int n, cyc, prev, w;
    n = 0; cyc = 0; prev = -1;
    req0 = 1'b1; req1 = 1'b1; wr0 = 1'b0; wr1 = 1'b0;
    while (n < 8 && cyc < 60) begin
      tick();
      cyc++;
      if (psel && !penable) begin
        w = gnt1 ? 1 : 0;
        checks++;
        if (w != (n % 2) || w == prev || gnt0 !== !gnt1) begin
          errors++;
          $display("FAIL fair_grant: transfer %0d gnt=%b%b, required requester %0d", n, gnt0, gnt1, n % 2);
        end
        prev = w;
        n++;
      end
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL fair_timeout: %0d transfers seen, required 8", n);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req0 = 1'b1; wr0 = 1'b0; addr0 = 8'h02;
    tick();
    req0 = 1'b0;
    tick();
    checks++;
    if (psel !== 1'b1 || penable !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_access: psel=%b pen=%b, required 1 1", psel, penable);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (psel !== 1'b0 || penable !== 1'b0 || gnt0 !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: psel=%b pen=%b gnt0=%b, required 0 0 0", psel, penable, gnt0);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (done0 !== 1'b0 || done1 !== 1'b0 || rdata0 !== '0 || psel !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_after: done=%b%b rdata0=%h psel=%b, required 00 0 0", done0, done1, rdata0, psel);
      end
    end
  endtask

  task automatic test_idle();
    req0 = 1'b0; req1 = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      checks++;
      if (psel !== 1'b0 || penable !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0) begin
        errors++;
        $display("FAIL idle_quiet: cycle %0d psel=%b pen=%b done=%b%b, required all 0", c, psel, penable, done0, done1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_readback();
    test_tie();
    test_fairness();
    test_reset_mid();
    test_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have port clk  input  1  APB clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req0, req1  input  1  requester transfer request.
REQ-006 SHALL have ports wr0, wr1  input  1  requester direction (1 = write, 0 = read).
REQ-007 SHALL have ports addr0, addr1  input  ADDR_W  requester address.
REQ-008 SHALL have ports wdata0, wdata1  input  DATA_W  requester write data.
REQ-009 SHALL have ports gnt0, gnt1  output  1  requester owns the bus; high during its SETUP and ACCESS cycles.
REQ-010 SHALL have ports done0, done1  output  1  one-cycle completion pulse.
REQ-011 SHALL have ports rdata0, rdata1  output  DATA_W  last read data returned to that requester.
REQ-012 SHALL have ports paddr  output  ADDR_W, pwrite  output  1, psel  output  1, penable  output  1, pwdata  output  DATA_W  APB master port.
REQ-013 SHALL have port prdata  input  DATA_W  APB read data from the slave.

Function
REQ-014 SHALL implement the FSM states IDLE, SETUP and ACCESS, with every APB output registered.
REQ-015 In IDLE, with at least one eligible request sampled at the rising edge, the FSM SHALL move to SETUP and latch the winner's wr/addr/wdata into pwrite/paddr/pwdata.
REQ-016 In SETUP, psel SHALL be 1 and penable SHALL be 0, and the FSM SHALL always move to ACCESS on the next edge.
REQ-017 In ACCESS, psel and penable SHALL both be 1, and the FSM SHALL always move to IDLE on the next edge (no wait states, no pready).
REQ-018 In IDLE, psel and penable SHALL be 0, and paddr/pwrite/pwdata SHALL hold their last values.
REQ-019 On the edge leaving ACCESS, the done of the granted requester SHALL be set for exactly one cycle (the following IDLE cycle).
REQ-020 On the edge leaving ACCESS of a read, rdata of the granted requester SHALL capture prdata.
REQ-021 rdata SHALL hold its value until that requester's next read completes, and writes SHALL NOT alter rdata.
REQ-022 A requester whose done is high in the current IDLE cycle SHALL be ineligible for arbitration at that edge, so that a request still held while done is seen is not re-granted.
REQ-023 Arbitration SHALL be round-robin: a single eligible request wins; with both eligible, the requester not granted most recently wins.
REQ-024 The last-grant pointer SHALL update only when a grant is issued.
REQ-025 Latency SHALL be: req high in an IDLE cycle at edge T -> SETUP in cycle T+1, ACCESS in T+2, done in T+3; minimum 3 cycles per transfer, with at least one IDLE cycle between transfers.
REQ-026 Requester inputs SHALL be don't-care after the grant edge.
REQ-027 A req deasserted after its grant SHALL NOT abort the transfer, and done SHALL still pulse.
REQ-028 gnt0 and gnt1 SHALL never be high simultaneously, and done0 and done1 SHALL never be high simultaneously.

Reset
REQ-029 On rst_n low, asynchronously and without waiting for clk, the block SHALL set: state IDLE; psel, penable, pwrite, gnt*, done* = 0; paddr, pwdata, rdata* = 0.
REQ-030 On rst_n low, the last-grant pointer SHALL be set to requester 1, so requester 0 wins the first tie.
REQ-031 A reset during SETUP or ACCESS SHALL abandon the transfer: no done pulse and no rdata update.
REQ-032 The first possible SETUP after reset release SHALL occur one cycle after the first rising edge at which rst_n is high and a request is present.

Verification
REQ-033 The bench SHALL cover a write: req0=1, wr0=1, addr0=0x02, wdata0=0x10 -> SETUP with paddr=0x02, pwrite=1, pwdata=0x10, psel=1, penable=0; then ACCESS with penable=1; then done0 for 1 cycle; gnt1/done1 stay 0.
REQ-034 The bench SHALL cover read-back: req0 read of addr 0x02 after the write above -> rdata0=0x10 in the done0 cycle; a following write by req0 to 0x04 with data 0x20 leaves rdata0=0x10.
REQ-035 The bench SHALL cover a tie after reset: req0 and req1 rise in the same cycle -> req0 served first, then req1 (addr1=0x08, wdata1=0x10, write) served with gnt1 high, and done1 following done0 by 3 cycles.
REQ-036 The bench SHALL cover fairness: both reqs held high continuously -> grants alternate 0,1,0,1 over 8 transfers, with no requester granted twice in a row.
REQ-037 The bench SHALL cover reset mid-transfer: rst_n driven low during ACCESS -> psel and penable go 0 before the next clk edge; no done; rdata unchanged at 0.
REQ-038 The bench SHALL cover no traffic: both reqs 0 for 100 cycles -> psel=0, penable=0, done*=0 throughout, with an assertion that penable is never 1 while psel is 0.
